// File: rtl/icode_fetch.sv
// -----------------------------------------------------------------------------
// icode_fetch
//
// Instruction fetch stage that feeds the ICODE input of lu_processor.
// It holds a small run-time loadable instruction memory, a wrapping program
// counter and a prefetch FIFO. When the FIFO is empty the block drives NOP_CODE,
// so the consumer never sees a stale instruction.
//
// Ports
//   clk          in   1   clock; all state changes on the rising edge
//   rst          in   1   asynchronous reset, active-high
//   en           in   1   fetch enable
//   prog_we      in   1   instruction memory write strobe
//   prog_addr    in   AW  instruction memory write address
//   prog_data    in   IW  instruction memory write data
//   jmp_valid    in   1   redirect request (highest priority)
//   jmp_addr     in   AW  redirect target
//   icode_ready  in   1   consumer accepts the head word this cycle
//   icode_valid  out  1   head word valid (FIFO non-empty)
//   ICODE        out  IW  head word when valid, NOP_CODE otherwise
//   pc_out       out  AW  address of the head word, 0 when empty
//   halted       out  1   fetch stopped on a HALT_CODE word
// -----------------------------------------------------------------------------
module icode_fetch #(
  parameter int              IW        = 8,
  parameter int              AW        = 4,
  parameter int              FD        = 4,
  parameter logic [IW-1:0]   NOP_CODE  = 8'h00,
  parameter logic [IW-1:0]   HALT_CODE = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  input  logic          icode_ready,
  output logic          icode_valid,
  output logic [IW-1:0] ICODE,
  output logic [AW-1:0] pc_out,
  output logic          halted
);

  localparam int             DEPTH  = 1 << AW;
  localparam int             PW     = $clog2(FD);
  localparam int             CW     = PW + 1;
  localparam logic [CW-1:0]  FD_CNT = CW'(FD);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;

  // Instruction memory and FIFO storage carry no reset; only the pointers and
  // the count decide what is valid.
  logic [IW-1:0] mem_q       [DEPTH];
  logic [IW-1:0] fifo_data_q [FD];
  logic [AW-1:0] fifo_addr_q [FD];

  logic          fifo_empty;
  logic          issue;
  logic          push;
  logic          pop;
  logic [IW-1:0] rd_word;
  logic          rd_is_halt;

  // ---------------------------------------------------------------------------
  // Read issue / push / pop
  // ---------------------------------------------------------------------------
  // The synchronous read lands directly in the FIFO slot at the edge that ends
  // the issuing cycle. That gives the one-cycle fetch latency, and it means no
  // read is ever outstanding across an edge, so the in-flight term of the room
  // check is always zero and the count alone bounds issue.
  // Reading the array before the write port updates it at the same edge gives
  // read-first behaviour on a same-address collision.
  always_comb begin
    fifo_empty = (count_q == '0);
    rd_word    = mem_q[pc_q];
    rd_is_halt = (rd_word == HALT_CODE);
    issue      = en && (state_q != ST_HALT) && !jmp_valid && (count_q < FD_CNT);
    push       = issue;
    // A jump flushes the FIFO, so a pop requested in the same cycle is dropped.
    pop        = !fifo_empty && icode_ready && !jmp_valid;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;

    if (jmp_valid) begin
      // Redirect: new pc, empty FIFO, and leave HALT.
      pc_d    = jmp_addr;
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      state_d = en ? ST_FETCH : ST_IDLE;
    end else begin
      if (issue) begin
        pc_d = pc_q + AW'(1);
      end
      if (push) begin
        wp_d = wp_q + PW'(1);
      end
      if (pop) begin
        rp_d = rp_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (push && rd_is_halt) begin
            state_d = ST_HALT;
          end else if (en) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The HALT word enters the FIFO at this edge; nothing is read after it.
          if (push && rd_is_halt) begin
            state_d = ST_HALT;
          end else if (!en) begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory write port (independent of fetch activity)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: each entry keeps the word and the address it came from
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data_q[wp_q] <= rd_word;
      fifo_addr_q[wp_q] <= pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: driven from registers only, never from inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    icode_valid = !fifo_empty;
    ICODE       = fifo_empty ? NOP_CODE : fifo_data_q[rp_q];
    pc_out      = fifo_empty ? '0 : fifo_addr_q[rp_q];
    halted      = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_icode_fetch.sv
// -----------------------------------------------------------------------------
// tb_icode_fetch
//
// Directed bench for icode_fetch: reset state, streaming, backpressure, jump
// with pc wrap, HALT handling and asynchronous reset in mid-stream.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_icode_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       jmp_valid;
  logic [3:0] jmp_addr;
  logic       icode_ready;
  logic       icode_valid;
  logic [7:0] ICODE;
  logic [3:0] pc_out;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Bench-side image of the instruction memory contents.
  logic [7:0] img [16];

  icode_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .icode_ready (icode_ready),
    .icode_valid (icode_valid),
    .ICODE       (ICODE),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] code,
                            input logic [3:0] pc);
    chk({tag, ".valid"}, {15'd0, icode_valid}, {15'd0, v});
    chk({tag, ".icode"}, {8'd0, ICODE}, {8'd0, code});
    chk({tag, ".pc"},    {12'd0, pc_out}, {12'd0, pc});
    $display("step %-12s valid=%0d icode=%h pc=%0d halted=%0d",
             tag, icode_valid, ICODE, pc_out, halted);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h60 + i);
    img[0]  = 8'h11;
    img[1]  = 8'h22;
    img[2]  = 8'h33;
    img[3]  = 8'h44;
    img[4]  = 8'h55;
    img[15] = 8'hA5;

    rst         = 1'b1;
    en          = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    jmp_valid   = 1'b0;
    jmp_addr    = '0;
    icode_ready = 1'b0;

    // Reset state.
    tick();
    expect_out("reset", 1'b0, 8'h00, 4'd0);
    chk("reset.halted", {15'd0, halted}, 16'd0);
    tick();
    rst = 1'b0;

    // Load the whole memory.
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = img[i];
      tick();
    end
    prog_we = 1'b0;

    // Streaming: one word per cycle starting one cycle after en.
    en          = 1'b1;
    icode_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out("stream", 1'b1, img[k], 4'(k));
    end
    en = 1'b0;
    tick();
    expect_out("drain", 1'b0, 8'h00, 4'd0);

    // Back to address 0 with nothing consumed.
    jmp_valid   = 1'b1;
    jmp_addr    = 4'd0;
    icode_ready = 1'b0;
    tick();
    jmp_valid = 1'b0;

    // Backpressure: head stays at mem[0] while the FIFO fills.
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out("hold", 1'b1, img[0], 4'd0);
    end
    // Release: following words arrive back to back, in order.
    icode_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      expect_out("release", 1'b1, img[k], 4'(k));
    end

    // Jump to 15 while streaming; pc then wraps to 0.
    jmp_valid = 1'b1;
    jmp_addr  = 4'd15;
    tick();
    expect_out("jmp_gap", 1'b0, 8'h00, 4'd0);
    jmp_valid = 1'b0;
    tick();
    expect_out("jmp_tgt", 1'b1, img[15], 4'd15);
    tick();
    expect_out("jmp_wrap", 1'b1, img[0], 4'd0);
    tick();
    expect_out("jmp_next", 1'b1, img[1], 4'd1);

    // HALT word at address 2, loaded in the same cycle as a jump to 0.
    en        = 1'b0;
    jmp_valid = 1'b1;
    jmp_addr  = 4'd0;
    prog_we   = 1'b1;
    prog_addr = 4'd2;
    prog_data = 8'hFF;
    img[2]    = 8'hFF;
    tick();
    expect_out("halt_flush", 1'b0, 8'h00, 4'd0);
    jmp_valid = 1'b0;
    prog_we   = 1'b0;
    en        = 1'b1;
    tick();
    expect_out("halt_w0", 1'b1, img[0], 4'd0);
    chk("halt_w0.halted", {15'd0, halted}, 16'd0);
    tick();
    expect_out("halt_w1", 1'b1, img[1], 4'd1);
    chk("halt_w1.halted", {15'd0, halted}, 16'd0);
    tick();
    expect_out("halt_word", 1'b1, 8'hFF, 4'd2);
    chk("halt_word.halted", {15'd0, halted}, 16'd1);
    tick();
    expect_out("halted1", 1'b0, 8'h00, 4'd0);
    chk("halted1.halted", {15'd0, halted}, 16'd1);
    tick();
    expect_out("halted2", 1'b0, 8'h00, 4'd0);
    chk("halted2.halted", {15'd0, halted}, 16'd1);

    // Jump out of HALT; restore mem[2] in the following cycle.
    jmp_valid = 1'b1;
    jmp_addr  = 4'd0;
    tick();
    expect_out("unhalt", 1'b0, 8'h00, 4'd0);
    chk("unhalt.halted", {15'd0, halted}, 16'd0);
    jmp_valid = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 4'd2;
    prog_data = 8'h33;
    img[2]    = 8'h33;
    tick();
    expect_out("restart", 1'b1, img[0], 4'd0);
    prog_we     = 1'b0;
    icode_ready = 1'b0;
    tick();
    expect_out("fill2", 1'b1, img[0], 4'd0);
    tick();
    expect_out("fill3", 1'b1, img[0], 4'd0);

    // Asynchronous reset with three words queued: outputs clear before an edge.
    rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 8'h00, 4'd0);
    chk("async_rst.halted", {15'd0, halted}, 16'd0);
    tick();
    tick();
    rst         = 1'b0;
    icode_ready = 1'b1;
    tick();
    expect_out("post_rst0", 1'b1, img[0], 4'd0);
    tick();
    expect_out("post_rst1", 1'b1, img[1], 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
